befehls_holer: RTL and testbench

Instruction fetch unit; the producer side of the instruction decoder's Instruktion/DekodierSignal interface. It holds the program counter and reads one 32-bit instruction word per request over a req/ready memory handshake. It delivers each word on a registered bus with a one-cycle DekodierSignal strobe. The control unit triggers fetches and supplies the jump information for the previously decoded instruction.

---
 rtl/hans_pkg.sv | 13 +
 rtl/naechste_adresse.sv | 26 ++
 rtl/befehls_holer.sv | 115 +++++++++++
 tb/tb_befehls_holer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hans_pkg.sv
// Shared types and constants for the instruction fetch path.
package hans_pkg;

  localparam int WORTBREITE = 32;
  localparam logic [WORTBREITE-1:0] NOP_WORT = 32'h0000_0000;

  typedef enum logic [1:0] {
    LEERLAUF = 2'd0,
    ANFRAGE  = 2'd1,
    AUSGABE  = 2'd2
  } holerZustand_t;

endpackage

// File: rtl/naechste_adresse.sv
// Combinational selection of the next fetch address: sequential PC,
// PC-relative branch or absolute register target.
module naechste_adresse
  import hans_pkg::*;
(
  input  logic [WORTBREITE-1:0] pc,
  input  logic [WORTBREITE-1:0] pcAlt,
  input  logic [WORTBREITE-1:0] versatz,
  input  logic [WORTBREITE-1:0] registerZiel,
  input  logic                  sprungNehmen,
  input  logic                  relativerSprung,
  input  logic                  absoluterSprung,
  output logic [WORTBREITE-1:0] ziel
);

  // Absolute wins over relative when the decoder flags both.
  always_comb begin
    ziel = pc;
    if (sprungNehmen && absoluterSprung) begin
      ziel = registerZiel;
    end else if (sprungNehmen && relativerSprung) begin
      ziel = pcAlt + versatz;
    end
  end

endmodule

// File: rtl/befehls_holer.sv
// Instruction fetch unit: holds the PC, reads one word per request over a
// req/ready handshake and presents it to the decoder with a one-cycle strobe.
module befehls_holer
  import hans_pkg::*;
#(
  parameter logic [WORTBREITE-1:0] START_ADRESSE = 32'h0000_0000,
  parameter int                    TIMEOUT       = 255
) (
  input  logic                  Takt,
  input  logic                  Reset,
  input  logic                  Holen,
  input  logic                  SprungNehmen,
  input  logic                  RelativerSprung,
  input  logic                  AbsoluterSprung,
  input  logic [WORTBREITE-1:0] Versatz,
  input  logic [WORTBREITE-1:0] RegisterZiel,
  output logic [WORTBREITE-1:0] SpeicherAdresse,
  output logic                  SpeicherLesen,
  input  logic                  SpeicherBereit,
  input  logic [WORTBREITE-1:0] SpeicherDaten,
  output logic [WORTBREITE-1:0] Instruktion,
  output logic                  DekodierSignal,
  output logic [WORTBREITE-1:0] BefehlsZaehler,
  output logic                  Beschaeftigt,
  output logic                  Fehler
);

  // The counter equals the number of completed wait cycles, so the request
  // gives up in the cycle where it would reach TIMEOUT.
  localparam logic [15:0] TIMEOUT_GRENZE = 16'(TIMEOUT - 1);

  holerZustand_t          zustand, zustandNext;
  logic [WORTBREITE-1:0]  pcReg;
  logic [WORTBREITE-1:0]  zielAdresse;
  logic [15:0]            zaehler;
  logic                   ersterBefehl;
  logic                   erfolg;
  logic                   zeitUeber;

  naechste_adresse uNaechsteAdresse (
    .pc              (pcReg),
    .pcAlt           (BefehlsZaehler),
    .versatz         (Versatz),
    .registerZiel    (RegisterZiel),
    .sprungNehmen    (SprungNehmen && !ersterBefehl),
    .relativerSprung (RelativerSprung),
    .absoluterSprung (AbsoluterSprung),
    .ziel            (zielAdresse)
  );

  always_comb begin
    zustandNext = zustand;
    erfolg      = 1'b0;
    zeitUeber   = 1'b0;
    case (zustand)
      LEERLAUF: begin
        if (Holen) zustandNext = ANFRAGE;
      end
      ANFRAGE: begin
        // Ready in the final allowed cycle still counts as a successful read.
        if (SpeicherBereit) begin
          erfolg      = 1'b1;
          zustandNext = AUSGABE;
        end else if (zaehler == TIMEOUT_GRENZE) begin
          zeitUeber   = 1'b1;
          zustandNext = LEERLAUF;
        end
      end
      AUSGABE:  zustandNext = LEERLAUF;
      default:  zustandNext = LEERLAUF;
    endcase
  end

  assign Beschaeftigt = (zustand != LEERLAUF);

  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) begin
      zustand         <= LEERLAUF;
      pcReg           <= START_ADRESSE;
      zaehler         <= '0;
      ersterBefehl    <= 1'b1;
      SpeicherAdresse <= '0;
      SpeicherLesen   <= 1'b0;
      Instruktion     <= NOP_WORT;
      BefehlsZaehler  <= '0;
      DekodierSignal  <= 1'b0;
      Fehler          <= 1'b0;
    end else begin
      zustand        <= zustandNext;
      DekodierSignal <= erfolg;
      if (zustand == LEERLAUF && Holen) begin
        SpeicherAdresse <= zielAdresse;
        SpeicherLesen   <= 1'b1;
        zaehler         <= '0;
      end else if (zustand == ANFRAGE) begin
        if (erfolg) begin
          Instruktion    <= SpeicherDaten;
          BefehlsZaehler <= SpeicherAdresse;
          pcReg          <= SpeicherAdresse + 32'd1;
          SpeicherLesen  <= 1'b0;
          ersterBefehl   <= 1'b0;
          zaehler        <= '0;
        end else if (zeitUeber) begin
          Fehler        <= 1'b1;
          SpeicherLesen <= 1'b0;
          Instruktion   <= NOP_WORT;
          zaehler       <= '0;
        end else begin
          zaehler <= zaehler + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_befehls_holer.sv
// Directed-vector bench for befehls_holer with a short memory timeout.
module tb_befehls_holer;

  logic        Takt = 1'b0;
  logic        Reset = 1'b1;
  logic        Holen = 1'b0;
  logic        SprungNehmen = 1'b0;
  logic        RelativerSprung = 1'b0;
  logic        AbsoluterSprung = 1'b0;
  logic [31:0] Versatz = '0;
  logic [31:0] RegisterZiel = '0;
  logic [31:0] SpeicherAdresse;
  logic        SpeicherLesen;
  logic        SpeicherBereit = 1'b0;
  logic [31:0] SpeicherDaten = '0;
  logic [31:0] Instruktion;
  logic        DekodierSignal;
  logic [31:0] BefehlsZaehler;
  logic        Beschaeftigt;
  logic        Fehler;

  int testsRun = 0;
  int testsFailed = 0;
  int strobes = 0;
  int strobesErwartet = 0;

  befehls_holer #(
    .START_ADRESSE (32'h0000_0000),
    .TIMEOUT       (4)
  ) dut (
    .Takt            (Takt),
    .Reset           (Reset),
    .Holen           (Holen),
    .SprungNehmen    (SprungNehmen),
    .RelativerSprung (RelativerSprung),
    .AbsoluterSprung (AbsoluterSprung),
    .Versatz         (Versatz),
    .RegisterZiel    (RegisterZiel),
    .SpeicherAdresse (SpeicherAdresse),
    .SpeicherLesen   (SpeicherLesen),
    .SpeicherBereit  (SpeicherBereit),
    .SpeicherDaten   (SpeicherDaten),
    .Instruktion     (Instruktion),
    .DekodierSignal  (DekodierSignal),
    .BefehlsZaehler  (BefehlsZaehler),
    .Beschaeftigt    (Beschaeftigt),
    .Fehler          (Fehler)
  );

  always #5 Takt = ~Takt;

  always @(posedge Takt) if (DekodierSignal) strobes++;

  task automatic pruefe(input string tag, input logic [31:0] ist, input logic [31:0] soll);
    testsRun++;
    if (ist !== soll) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, ist, soll);
    end
  endtask

  // One fetch: Holen with jump inputs, `warte` wait cycles, then Bereit with `daten`.
  task automatic holeBefehl(input bit sn, input bit rel, input bit abso,
                            input logic [31:0] vers, input logic [31:0] ziel,
                            input int warte, input logic [31:0] daten,
                            input logic [31:0] erwAdr, input bit holenImWarten);
    @(negedge Takt);
    Holen = 1'b1; SprungNehmen = sn; RelativerSprung = rel; AbsoluterSprung = abso;
    Versatz = vers; RegisterZiel = ziel;
    @(negedge Takt);
    Holen = 1'b0; SprungNehmen = 1'b0; RelativerSprung = 1'b0; AbsoluterSprung = 1'b0;
    pruefe("adresse", SpeicherAdresse, erwAdr);
    pruefe("lesen_an", {31'b0, SpeicherLesen}, 32'd1);
    pruefe("beschaeftigt", {31'b0, Beschaeftigt}, 32'd1);
    for (int i = 0; i < warte; i++) begin
      if (holenImWarten) Holen = 1'b1;
      @(negedge Takt);
      Holen = 1'b0;
      pruefe("warten_lesen", {31'b0, SpeicherLesen}, 32'd1);
      pruefe("warten_dek", {31'b0, DekodierSignal}, 32'd0);
    end
    pruefe("adresse_stabil", SpeicherAdresse, erwAdr);
    SpeicherBereit = 1'b1; SpeicherDaten = daten;
    @(negedge Takt);
    SpeicherBereit = 1'b0; SpeicherDaten = 32'hDEAD_BEEF;
    strobesErwartet++;
    pruefe("dek_puls", {31'b0, DekodierSignal}, 32'd1);
    pruefe("instruktion", Instruktion, daten);
    pruefe("befehlszaehler", BefehlsZaehler, erwAdr);
    pruefe("lesen_aus", {31'b0, SpeicherLesen}, 32'd0);
    @(negedge Takt);
    pruefe("dek_ende", {31'b0, DekodierSignal}, 32'd0);
    pruefe("leerlauf", {31'b0, Beschaeftigt}, 32'd0);
    $display("[TB] fetch addr=%h data=%h waits=%0d", erwAdr, daten, warte);
  endtask

  initial begin
    repeat (2) @(negedge Takt);
    pruefe("rst_instr", Instruktion, 32'h0);
    pruefe("rst_bz", BefehlsZaehler, 32'h0);
    pruefe("rst_adr", SpeicherAdresse, 32'h0);
    pruefe("rst_sig", {27'b0, SpeicherLesen, DekodierSignal, Beschaeftigt, Fehler, 1'b0}, 32'h0);
    Reset = 1'b0;
    $display("[TB] reset released");

    // First fetch ignores jump inputs.
    holeBefehl(1, 0, 1, 32'h0, 32'h55, 0, 32'hE000_1234, 32'h0, 0);
    holeBefehl(0, 0, 0, 32'h0, 32'h0, 3, 32'h1111_0001, 32'h1, 1);
    holeBefehl(0, 0, 0, 32'h0, 32'h0, 3, 32'h1111_0002, 32'h2, 1);
    holeBefehl(0, 0, 0, 32'h0, 32'h0, 3, 32'h1111_0003, 32'h3, 1);
    holeBefehl(1, 0, 1, 32'h0, 32'd10, 1, 32'h2222_000A, 32'd10, 0);
    holeBefehl(1, 1, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h3333_0006, 32'd6, 0);
    holeBefehl(1, 1, 1, 32'hFFFF_FFFC, 32'h100, 2, 32'h4444_0100, 32'h100, 0);
    holeBefehl(0, 1, 1, 32'h10, 32'h999, 0, 32'h5555_0101, 32'h101, 0);

    // Timeout: Bereit never arrives.
    @(negedge Takt);
    Holen = 1'b1;
    @(negedge Takt);
    Holen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pruefe("to_lesen", {31'b0, SpeicherLesen}, 32'd1);
      pruefe("to_fehler_vorher", {31'b0, Fehler}, 32'd0);
      @(negedge Takt);
    end
    pruefe("to_lesen_aus", {31'b0, SpeicherLesen}, 32'd0);
    pruefe("to_fehler", {31'b0, Fehler}, 32'd1);
    pruefe("to_instr_nop", Instruktion, 32'h0);
    pruefe("to_kein_dek", {31'b0, DekodierSignal}, 32'd0);
    pruefe("to_leerlauf", {31'b0, Beschaeftigt}, 32'd0);
    $display("[TB] timeout at addr 00000102");
    holeBefehl(0, 0, 0, 32'h0, 32'h0, 0, 32'h6666_0102, 32'h102, 0);
    pruefe("fehler_klebt", {31'b0, Fehler}, 32'd1);

    // Address wrap.
    holeBefehl(1, 0, 1, 32'h0, 32'hFFFF_FFFF, 0, 32'h7777_FFFF, 32'hFFFF_FFFF, 0);
    holeBefehl(0, 0, 0, 32'h0, 32'h0, 0, 32'h8888_0000, 32'h0, 0);
    holeBefehl(0, 0, 0, 32'h0, 32'h0, 0, 32'h8888_0001, 32'h1, 0);

    // Asynchronous reset in the middle of a request.
    @(negedge Takt);
    Holen = 1'b1;
    @(negedge Takt);
    Holen = 1'b0;
    pruefe("vor_rst_lesen", {31'b0, SpeicherLesen}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    pruefe("arst_adr", SpeicherAdresse, 32'h0);
    pruefe("arst_instr", Instruktion, 32'h0);
    pruefe("arst_bz", BefehlsZaehler, 32'h0);
    pruefe("arst_sig", {28'b0, SpeicherLesen, DekodierSignal, Beschaeftigt, Fehler}, 32'h0);
    $display("[TB] async reset mid-request");
    @(negedge Takt);
    Reset = 1'b0;
    holeBefehl(1, 1, 1, 32'h40, 32'h77, 0, 32'h9999_0000, 32'h0, 0);
    holeBefehl(0, 0, 0, 32'h0, 32'h0, 1, 32'h9999_0001, 32'h1, 0);

    repeat (2) @(negedge Takt);
    pruefe("strobe_anzahl", strobes, strobesErwartet);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
